// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache:
// controller state type and default geometry.
package data_cache_pkg;

  localparam int MEM_W_DEFAULT = 16;
  localparam int LINES_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_MISS = 2'd1,
    ST_WR_MEM  = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/dcache_array.sv
// Line storage for the data cache: per-line valid bit, tag and one data word.
// Combinational read port, single posedge write port that also sets valid.
module dcache_array
  import data_cache_pkg::*;
#(
  parameter  int LINES  = LINES_DEFAULT,
  parameter  int TAG_W  = MEM_W_DEFAULT - $clog2(LINES_DEFAULT),
  parameter  int DATA_W = MEM_W_DEFAULT,
  localparam int IDX_W  = $clog2(LINES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  // NOTE: state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // NOTE: tag/data storage is deliberately not reset; valid bits alone gate its use,
  // which keeps this a plain RAM-style array.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Load hits complete in the request cycle; misses and stores stall until mem_ack.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int LINES = LINES_DEFAULT,
  parameter int MEM_W = MEM_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [MEM_W-1:0] addr,
  input  logic [MEM_W-1:0] wdata,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic [MEM_W-1:0] read_data,
  output logic             hit,
  output logic             mem_req,
  output logic             mem_we,
  output logic [MEM_W-1:0] mem_addr,
  output logic [MEM_W-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [MEM_W-1:0] mem_rdata
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = MEM_W - IDX_W;

  state_e           state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [MEM_W-1:0] mem_addr_q, mem_addr_d;
  logic [MEM_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [MEM_W-1:0] ret_q, ret_d;

  logic [MEM_W-1:0] look_addr;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [MEM_W-1:0] rd_data;
  logic             lookup_hit;
  logic             wr_en;
  logic [MEM_W-1:0] wr_data;
  logic             hit_c;
  logic [MEM_W-1:0] read_data_c;

  // Outside IDLE the lookup follows the captured request, not the live inputs.
  assign look_addr  = (state_q == ST_IDLE) ? addr : mem_addr_q;
  assign lookup_hit = rd_valid && (rd_tag == look_addr[MEM_W-1:IDX_W]);

  dcache_array #(
    .LINES (LINES),
    .TAG_W (TAG_W),
    .DATA_W(MEM_W)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx_i  (look_addr[IDX_W-1:0]),
    .rd_valid_o(rd_valid),
    .rd_tag_o  (rd_tag),
    .rd_data_o (rd_data),
    .wr_en_i   (wr_en),
    .wr_idx_i  (mem_addr_q[IDX_W-1:0]),
    .wr_tag_i  (mem_addr_q[MEM_W-1:IDX_W]),
    .wr_data_i (wr_data)
  );

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ret_d       = ret_q;
    hit_c       = 1'b1;
    read_data_c = '0;
    wr_en       = 1'b0;
    wr_data     = mem_rdata;

    case (state_q)
      ST_IDLE: begin
        if (mem_write) begin
          // Simultaneous read+write is handled as a store.
          hit_c       = 1'b0;
          state_d     = ST_WR_MEM;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr;
          mem_wdata_d = wdata;
        end else if (mem_read) begin
          if (lookup_hit) begin
            read_data_c = rd_data;
          end else begin
            hit_c      = 1'b0;
            state_d    = ST_RD_MISS;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = addr;
          end
        end
      end

      ST_RD_MISS: begin
        hit_c = 1'b0;
        if (mem_ack) begin
          wr_en     = 1'b1;
          wr_data   = mem_rdata;
          ret_d     = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = ST_DONE;
        end
      end

      ST_WR_MEM: begin
        hit_c = 1'b0;
        if (mem_ack) begin
          // Write-update only when the line already holds this address.
          wr_en     = lookup_hit;
          wr_data   = mem_wdata_q;
          mem_req_d = 1'b0;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        read_data_c = mem_we_q ? '0 : ret_q;
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ret_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ret_q       <= ret_d;
    end
  end

  // Pipeline sees "no stall, no data" for as long as reset is held.
  assign hit       = hit_c | ~rst_n;
  assign read_data = rst_n ? read_data_c : '0;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus randomized loads/stores
// compared against an address-level cache and memory model.
module tb_data_cache;

  localparam int LINES = 8;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] read_data;
  logic        hit;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  int n_vec  = 0;
  int n_fail = 0;

  // Model: each line remembers which full address it holds and its word.
  bit          mv    [LINES];
  logic [15:0] maddr [LINES];
  logic [15:0] mdata [LINES];
  logic [15:0] mem_model [logic [15:0]];

  data_cache #(.LINES(LINES), .MEM_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .wdata    (wdata),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .read_data(read_data),
    .hit      (hit),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
  endfunction

  // One pipeline access, called and returning one time unit after a posedge.
  task automatic access(input bit rd, input bit wr, input logic [15:0] a,
                        input logic [15:0] d, input int wait_cyc,
                        output logic [15:0] got, output bit missed);
    int          idx;
    bit          is_store;
    bit          hit_now;
    logic [15:0] rv;
    idx      = int'(a) % LINES;
    is_store = wr;
    hit_now  = !is_store && mv[idx] && (maddr[idx] == a);
    missed   = !hit_now;
    mem_read = rd; mem_write = wr; addr = a; wdata = d;
    @(negedge clk);
    check("req_cycle_hit", hit, hit_now);
    check("req_cycle_mem_req", mem_req, 0);
    if (hit_now) begin
      check("load_hit_data", read_data, mdata[idx]);
      got = read_data;
      tick();
      mem_read = 1'b0; mem_write = 1'b0;
      return;
    end
    tick();
    rv = mem_val(a);
    for (int c = 0; c <= wait_cyc; c++) begin
      if (c == wait_cyc) begin
        mem_ack   = 1'b1;
        mem_rdata = is_store ? 16'($urandom) : rv;
      end
      @(negedge clk);
      check("stall_hit", hit, 0);
      check("stall_mem_req", mem_req, 1);
      check("stall_mem_we", mem_we, is_store);
      check("stall_mem_addr", mem_addr, a);
      if (is_store) check("stall_mem_wdata", mem_wdata, d);
      tick();
      mem_ack = 1'b0;
    end
    @(negedge clk);
    check("done_hit", hit, 1);
    check("done_read_data", read_data, is_store ? 16'h0 : rv);
    check("done_mem_req", mem_req, 0);
    got = read_data;
    if (is_store) begin
      mem_model[a] = d;
      if (mv[idx] && maddr[idx] == a) mdata[idx] = d;
    end else begin
      mv[idx] = 1'b1; maddr[idx] = a; mdata[idx] = rv;
    end
    tick();
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic idle_cycle(input bit spurious_ack);
    mem_ack   = spurious_ack;
    mem_rdata = 16'($urandom);
    @(negedge clk);
    check("idle_hit", hit, 1);
    check("idle_read_data", read_data, 0);
    check("idle_mem_req", mem_req, 0);
    tick();
    mem_ack = 1'b0;
  endtask

  initial begin
    logic [15:0] got;
    bit          missed;
    int          r;
    logic [15:0] a;

    rst_n = 1'b0; addr = '0; wdata = '0; mem_read = 1'b1; mem_write = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    #2;
    check("rst_hit", hit, 1);
    check("rst_read_data", read_data, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    mem_read = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    idle_cycle(0);

    // Cold load miss, then zero-stall re-load.
    mem_model[16'h0005] = 16'hBEEF;
    access(1, 0, 16'h0005, 16'h0, 2, got, missed);
    check("cold_load_missed", missed, 1);
    check("cold_load_data", got, 16'hBEEF);
    access(1, 0, 16'h0005, 16'h0, 0, got, missed);
    check("reload_missed", missed, 0);
    check("reload_data", got, 16'hBEEF);

    // Write-through with write-update of a resident line.
    access(0, 1, 16'h0005, 16'h1234, 1, got, missed);
    check("store_read_data", got, 16'h0000);
    access(1, 0, 16'h0005, 16'h0, 0, got, missed);
    check("post_store_missed", missed, 0);
    check("post_store_data", got, 16'h1234);

    // Conflict on index 3.
    mem_model[16'h0003] = 16'h1111;
    mem_model[16'h000B] = 16'h2222;
    access(1, 0, 16'h0003, 16'h0, 0, got, missed);
    check("fill3_data", got, 16'h1111);
    access(1, 0, 16'h000B, 16'h0, 1, got, missed);
    check("conflict_missed", missed, 1);
    check("conflict_data", got, 16'h2222);
    access(1, 0, 16'h0003, 16'h0, 0, got, missed);
    check("evicted_missed", missed, 1);
    check("evicted_data", got, 16'h1111);

    // No write-allocate.
    access(0, 1, 16'h0020, 16'h5A5A, 0, got, missed);
    access(1, 0, 16'h0020, 16'h0, 0, got, missed);
    check("no_alloc_missed", missed, 1);
    check("no_alloc_data", got, 16'h5A5A);

    // Reset while a read miss is outstanding.
    mem_read = 1'b1; addr = 16'h0040;
    @(negedge clk);
    check("abort_req_cycle_hit", hit, 0);
    tick();
    @(negedge clk);
    check("abort_pending_req", mem_req, 1);
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_mem_req", mem_req, 0);
    check("abort_hit", hit, 1);
    check("abort_read_data", read_data, 0);
    model_reset();
    mem_read = 1'b0;
    tick();
    rst_n = 1'b1;
    idle_cycle(1);
    access(1, 0, 16'h0040, 16'h0, 0, got, missed);
    check("after_abort_missed", missed, 1);
    access(1, 0, 16'h0005, 16'h0, 0, got, missed);
    check("after_reset_old_line_missed", missed, 1);
    check("after_reset_old_line_data", got, 16'h1234);

    // Read+write together is a store; spurious ack in IDLE is ignored.
    access(1, 1, 16'h0010, 16'hCAFE, 1, got, missed);
    check("rw_both_read_data", got, 16'h0000);
    idle_cycle(1);
    access(1, 0, 16'h0010, 16'h0, 0, got, missed);
    check("rw_both_then_load_missed", missed, 1);
    check("rw_both_then_load_data", got, 16'hCAFE);
    access(1, 0, 16'h0010, 16'h0, 0, got, missed);
    check("rw_both_reload_missed", missed, 0);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
      if (r < 50)      access(1, 0, a, 16'h0, $urandom_range(0, 3), got, missed);
      else if (r < 85) access(0, 1, a, 16'($urandom), $urandom_range(0, 3), got, missed);
      else             access(1, 1, a, 16'($urandom), $urandom_range(0, 3), got, missed);
      for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle($urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
